// File: rtl/rpn_sequencer.sv
// rpn_sequencer: token-level controller for the RPN operand stack.
// Accepts number/operator tokens on a valid/ready handshake, validates them
// against the stack occupancy, runs the ALU and issues one stack strobe per
// cycle. The stack itself lives outside this block.
// Optional feature: define RPN_DIV_EN to build the unsigned divider (opcode 9).
module rpn_sequencer #(
  parameter int DW    = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tok_valid,
  output logic             tok_ready,
  input  logic             tok_is_op,
  input  logic [3:0]       tok_op,
  input  logic [DW-1:0]    tok_data,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [DW-1:0]    stk_wdata,
  input  logic [DW-1:0]    stk_top,
  input  logic [DW-1:0]    stk_next,
  input  logic [CNT_W-1:0] stk_cnt,
  input  logic             stk_full,
  input  logic             stk_empty,
  output logic             res_valid,
  output logic [DW-1:0]    res_data,
  output logic             busy,
  output logic             err,
  output logic [2:0]       err_code,
  input  logic             err_clr
);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_LATCH, S_POP_A, S_POP_B, S_PUSH, S_CLR, S_DONE, S_ERR
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NEG  = 4'd6;
  localparam logic [3:0] OP_DUP  = 4'd7;
  localparam logic [3:0] OP_DROP = 4'd8;
  localparam logic [3:0] OP_DIV  = 4'd9;
  localparam logic [3:0] OP_CLR  = 4'd10;

  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_UNF  = 3'd1;
  localparam logic [2:0] ERR_OVF  = 3'd2;
  localparam logic [2:0] ERR_ILL  = 3'd3;
  localparam logic [2:0] ERR_DIV0 = 3'd4;

`ifdef RPN_DIV_EN
  localparam bit DIV_BUILT = 1'b1;
`else
  localparam bit DIV_BUILT = 1'b0;
`endif

  state_t           state;
  logic             is_op_q;    // latched token kind
  logic [3:0]       op_q;       // latched opcode
  logic [DW-1:0]    val_q;      // value to push and to report as res_data
  logic             cnt_ge2_q;  // occupancy >= 2 seen in CHECK (DROP result)
  logic [CNT_W-1:0] clr_left;   // pops still owed by CLR
  logic [2:0]       chk_code;
  logic [DW-1:0]    alu_res;

  // Two-operand ops consume next and top and push one result.
  function automatic logic is_binary(input logic [3:0] op);
    return (op <= OP_XOR) || (DIV_BUILT && (op == OP_DIV));
  endfunction

  function automatic logic op_legal(input logic [3:0] op);
    return is_binary(op) || (op inside {OP_NEG, OP_DUP, OP_DROP, OP_CLR});
  endfunction

  // Token validation against the current stack occupancy (used in CHECK).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    chk_code = ERR_NONE;
    if (!is_op_q) begin
      if (stk_full) chk_code = ERR_OVF;
    end else if (!op_legal(op_q)) begin
      chk_code = ERR_ILL;
    end else if (is_binary(op_q)) begin
      if (stk_cnt < CNT_W'(2)) chk_code = ERR_UNF;
    end else if (op_q != OP_CLR) begin
      if (stk_cnt == '0)                     chk_code = ERR_UNF;
      else if ((op_q == OP_DUP) && stk_full) chk_code = ERR_OVF;
    end
  end

  // ALU on the live stack outputs; its result is registered in LATCH.
  always_comb begin
    alu_res = '0;
    unique case (op_q)
      OP_ADD:  alu_res = stk_next + stk_top;
      OP_SUB:  alu_res = stk_next - stk_top;
      OP_MUL:  alu_res = stk_next * stk_top;
      OP_AND:  alu_res = stk_next & stk_top;
      OP_OR:   alu_res = stk_next | stk_top;
      OP_XOR:  alu_res = stk_next ^ stk_top;
      OP_NEG:  alu_res = '0 - stk_top;
      OP_DUP:  alu_res = stk_top;
      OP_DROP: alu_res = cnt_ge2_q ? stk_next : '0;
`ifdef RPN_DIV_EN
      OP_DIV:  alu_res = (stk_top == '0) ? '0 : stk_next / stk_top;
`endif
      default: alu_res = '0;
    endcase
  end

  // Sequencer FSM with registered handshake, strobe and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      tok_ready <= 1'b1;
      busy      <= 1'b0;
      stk_push  <= 1'b0;
      stk_pop   <= 1'b0;
      stk_wdata <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      is_op_q   <= 1'b0;
      op_q      <= '0;
      val_q     <= '0;
      cnt_ge2_q <= 1'b0;
      clr_left  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees last cycle's state.
      stk_push  <= 1'b0;
      stk_pop   <= 1'b0;
      res_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (tok_valid) begin
            is_op_q   <= tok_is_op;
            op_q      <= tok_op;
            val_q     <= tok_data;
            tok_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= S_CHECK;
          end
        end
        S_CHECK: begin
          cnt_ge2_q <= (stk_cnt >= CNT_W'(2));
          if (chk_code != ERR_NONE) begin
            err      <= 1'b1;
            err_code <= chk_code;
            state    <= S_ERR;
          end else if (!is_op_q) begin
            stk_push  <= 1'b1;
            stk_wdata <= val_q;
            state     <= S_PUSH;
          end else if (op_q == OP_CLR) begin
            // Pop count is fixed here; the stack is not re-sampled between pops.
            val_q    <= '0;
            clr_left <= stk_empty ? '0 : stk_cnt;
            stk_pop  <= !stk_empty;
            state    <= S_CLR;
          end else begin
            state <= S_LATCH;
          end
        end
        S_LATCH: begin
          if ((op_q == OP_DIV) && (stk_top == '0)) begin
            err      <= 1'b1;
            err_code <= ERR_DIV0;
            state    <= S_ERR;
          end else begin
            val_q <= alu_res;
            if (op_q == OP_DUP) begin
              stk_push  <= 1'b1;
              stk_wdata <= alu_res;
              state     <= S_PUSH;
            end else begin
              stk_pop <= 1'b1;
              state   <= S_POP_A;
            end
          end
        end
        S_POP_A: begin
          if (is_binary(op_q)) begin
            stk_pop <= 1'b1;
            state   <= S_POP_B;
          end else if (op_q == OP_NEG) begin
            stk_push  <= 1'b1;
            stk_wdata <= val_q;
            state     <= S_PUSH;
          end else begin
            res_valid <= 1'b1;
            res_data  <= val_q;
            state     <= S_DONE;
          end
        end
        S_POP_B: begin
          stk_push  <= 1'b1;
          stk_wdata <= val_q;
          state     <= S_PUSH;
        end
        S_PUSH: begin
          res_valid <= 1'b1;
          res_data  <= val_q;
          state     <= S_DONE;
        end
        S_CLR: begin
          if (clr_left > CNT_W'(1)) begin
            clr_left <= clr_left - CNT_W'(1);
            stk_pop  <= 1'b1;
          end else begin
            clr_left  <= '0;
            res_valid <= 1'b1;
            res_data  <= '0;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          tok_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        S_ERR: begin
          if (err_clr) begin
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            tok_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_sequencer.sv
// tb_rpn_sequencer: self-checking bench for rpn_sequencer. Emulates the
// external 32-entry stack, drives directed and random tokens and compares
// against a queue-based reference model of the token semantics.
module tb_rpn_sequencer;

  localparam int DW    = 32;
  localparam int CNT_W = 6;
  localparam int DEPTH = 32;

`ifdef RPN_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             tok_valid = 1'b0;
  logic             tok_ready;
  logic             tok_is_op = 1'b0;
  logic [3:0]       tok_op = '0;
  logic [DW-1:0]    tok_data = '0;
  logic             stk_push;
  logic             stk_pop;
  logic [DW-1:0]    stk_wdata;
  logic [DW-1:0]    stk_top = '0;
  logic [DW-1:0]    stk_next = '0;
  logic [CNT_W-1:0] stk_cnt = '0;
  logic             stk_full = 1'b0;
  logic             stk_empty = 1'b1;
  logic             res_valid;
  logic [DW-1:0]    res_data;
  logic             busy;
  logic             err;
  logic [2:0]       err_code;
  logic             err_clr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int overlap  = 0;

  logic [DW-1:0] mem[$];    // emulated stack block
  logic [DW-1:0] ref_q[$];  // reference model stack

  rpn_sequencer #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_op(tok_is_op),
    .tok_op(tok_op), .tok_data(tok_data),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_wdata(stk_wdata),
    .stk_top(stk_top), .stk_next(stk_next), .stk_cnt(stk_cnt),
    .stk_full(stk_full), .stk_empty(stk_empty),
    .res_valid(res_valid), .res_data(res_data), .busy(busy),
    .err(err), .err_code(err_code), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Stack block emulation: applies strobes, reset by the same event as the DUT.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem.delete();
    end else begin
      if (stk_push && stk_pop) overlap++;
      if (stk_pop && mem.size() > 0) void'(mem.pop_back());
      if (stk_push && mem.size() < DEPTH) mem.push_back(stk_wdata);
    end
    stk_cnt   <= CNT_W'(mem.size());
    stk_top   <= (mem.size() > 0) ? mem[mem.size()-1] : '0;
    stk_next  <= (mem.size() > 1) ? mem[mem.size()-2] : '0;
    stk_full  <= (mem.size() == DEPTH);
    stk_empty <= (mem.size() == 0);
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference semantics: expected error code, completion cycle and result.
  task automatic predict(input logic is_op, input logic [3:0] op, input logic [DW-1:0] d,
                         output logic [2:0] code, output int lat, output logic [DW-1:0] res);
    int n;
    logic [DW-1:0] a, b;
    n = ref_q.size();
    a = (n > 0) ? ref_q[n-1] : '0;
    b = (n > 1) ? ref_q[n-2] : '0;
    code = 3'd0;
    lat  = 0;
    res  = '0;
    if (!is_op) begin
      if (n == DEPTH) code = 3'd2;
      else begin ref_q.push_back(d); res = d; lat = 3; end
    end else if (op >= 11 || (op == 9 && !DIV_EN)) begin
      code = 3'd3;
    end else if (op <= 5 || op == 9) begin
      if (n < 2) code = 3'd1;
      else if (op == 9 && a == 0) code = 3'd4;
      else begin
        case (op)
          0: res = b + a;
          1: res = b - a;
          2: res = b * a;
          3: res = b & a;
          4: res = b | a;
          5: res = b ^ a;
          default: res = b / a;
        endcase
        void'(ref_q.pop_back());
        void'(ref_q.pop_back());
        ref_q.push_back(res);
        lat = 6;
      end
    end else if (op == 10) begin
      lat = 2 + ((n > 0) ? n : 1);
      ref_q.delete();
    end else if (n < 1) begin
      code = 3'd1;
    end else if (op == 7) begin
      if (n == DEPTH) code = 3'd2;
      else begin ref_q.push_back(a); res = a; lat = 4; end
    end else if (op == 6) begin
      void'(ref_q.pop_back());
      res = -a;
      ref_q.push_back(res);
      lat = 5;
    end else begin
      void'(ref_q.pop_back());
      res = (ref_q.size() > 0) ? ref_q[ref_q.size()-1] : '0;
      lat = 4;
    end
    if (code == 3'd4) lat = 3;
    else if (code != 3'd0) lat = 2;
  endtask

  task automatic do_reset();
    tok_valid = 1'b0;
    err_clr   = 1'b0;
    rst       = 1'b0;
    ref_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // Offers a token; returns with the DUT in its first post-acceptance cycle.
  task automatic offer(input logic is_op, input logic [3:0] op, input logic [DW-1:0] d, output bit ok);
    tok_valid = 1'b1;
    tok_is_op = is_op;
    tok_op    = op;
    tok_data  = d;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (tok_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    tok_valid = 1'b0;
  endtask

  task automatic run_token(input logic is_op, input logic [3:0] op, input logic [DW-1:0] d,
                           output logic [DW-1:0] got_res);
    logic [2:0] code;
    int lat, cyc;
    logic [DW-1:0] res;
    bit ok;
    got_res = '0;
    predict(is_op, op, d, code, lat, res);
    offer(is_op, op, d, ok);
    if (!ok) begin
      check("accept_timeout", 32'd0, 32'd1);
      do_reset();
      return;
    end
    cyc = 1;
    while (!res_valid && !err && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!res_valid && !err) begin
      check("done_timeout", 32'(cyc), 32'(lat));
      do_reset();
      return;
    end
    got_res = res_data;
    if (code == 3'd0) begin
      check("res_valid", {31'd0, res_valid}, 32'd1);
      check("latency", 32'(cyc), 32'(lat));
      check("res_data", res_data, res);
      check("err_quiet", {31'd0, err}, 32'd0);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
        check("pulse_once", {31'd0, res_valid}, 32'd0);
        check("ready_back", {31'd0, tok_ready}, 32'd1);
      end
    end else begin
      check("err_flag", {31'd0, err}, 32'd1);
      check("err_code", {29'd0, err_code}, {29'd0, code});
      check("err_latency", 32'(cyc), 32'(lat));
      check("err_not_ready", {31'd0, tok_ready}, 32'd0);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        @(posedge clk); #1;
        check("err_no_strobe", {30'd0, stk_push, stk_pop}, 32'd0);
      end
      check("err_code_held", {29'd0, err_code}, {29'd0, code});
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      check("err_cleared", {28'd0, err, err_code}, 32'd0);
      check("ready_after_clr", {31'd0, tok_ready}, 32'd1);
    end
    check("stk_cnt", {26'd0, stk_cnt}, 32'(ref_q.size()));
    if (ref_q.size() > 0) check("stk_top", stk_top, ref_q[ref_q.size()-1]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, tok_ready}, 32'd1);
    check({tag, "_ctrl"}, {26'd0, busy, stk_push, stk_pop, res_valid, err, 1'b0}, 32'd0);
    check({tag, "_code"}, {29'd0, err_code}, 32'd0);
    check({tag, "_res"}, res_data, 32'd0);
    check({tag, "_wdata"}, stk_wdata, 32'd0);
  endtask

  initial begin
    logic [DW-1:0] r;
    bit ok;
    int pick;
    logic [3:0] op;
    logic [DW-1:0] d;

    #1 rst = 1'b0;
    #2;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // push 7, push 5, SUB
    run_token(1'b0, 4'd0, 32'd7, r);
    run_token(1'b0, 4'd0, 32'd5, r);
    run_token(1'b1, 4'd1, 32'd0, r);
    check("sub_res", r, 32'd2);
    check("sub_cnt", {26'd0, stk_cnt}, 32'd1);

    // underflow: single operand then ADD
    run_token(1'b1, 4'd10, 32'd0, r);
    run_token(1'b0, 4'd0, 32'd3, r);
    run_token(1'b1, 4'd0, 32'd0, r);
    check("unf_cnt", {26'd0, stk_cnt}, 32'd1);

    // overflow: full stack then one more push and a DUP
    run_token(1'b1, 4'd10, 32'd0, r);
    for (int i = 0; i < DEPTH; i++) run_token(1'b0, 4'd0, 32'(i + 100), r);
    run_token(1'b0, 4'd0, 32'd9, r);
    run_token(1'b1, 4'd7, 32'd0, r);
    check("ovf_cnt", {26'd0, stk_cnt}, 32'd32);
    check("ovf_top", stk_top, 32'd131);

    // MUL wraps, NEG of the result
    run_token(1'b1, 4'd10, 32'd0, r);
    run_token(1'b0, 4'd0, 32'hFFFF_FFFF, r);
    run_token(1'b0, 4'd0, 32'd2, r);
    run_token(1'b1, 4'd2, 32'd0, r);
    check("mul_res", r, 32'hFFFF_FFFE);
    run_token(1'b1, 4'd6, 32'd0, r);
    check("neg_res", r, 32'd2);

    // divide by zero (code depends on build)
    run_token(1'b1, 4'd10, 32'd0, r);
    run_token(1'b0, 4'd0, 32'd9, r);
    run_token(1'b0, 4'd0, 32'd0, r);
    run_token(1'b1, 4'd9, 32'd0, r);
    check("div0_cnt", {26'd0, stk_cnt}, 32'd2);

    // CLR of a populated stack, then CLR of an empty stack
    run_token(1'b0, 4'd0, 32'd1, r);
    run_token(1'b0, 4'd0, 32'd2, r);
    run_token(1'b0, 4'd0, 32'd3, r);
    run_token(1'b1, 4'd10, 32'd0, r);
    check("clr_empty", {31'd0, stk_empty}, 32'd1);
    check("clr_res", r, 32'd0);
    run_token(1'b1, 4'd10, 32'd0, r);

    // DUP and DROP on a one-entry stack, illegal opcode
    run_token(1'b0, 4'd0, 32'h1234, r);
    run_token(1'b1, 4'd7, 32'd0, r);
    run_token(1'b1, 4'd8, 32'd0, r);
    run_token(1'b1, 4'd8, 32'd0, r);
    run_token(1'b1, 4'd13, 32'd0, r);

    // reset in the middle of an ADD
    run_token(1'b0, 4'd0, 32'd1, r);
    run_token(1'b0, 4'd0, 32'd2, r);
    offer(1'b1, 4'd0, 32'd0, ok);
    check("midrst_accept", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    check("midrst_cnt", {26'd0, stk_cnt}, 32'd0);
    ref_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // randomized token stream
    for (int t = 0; t < 300; t++) begin
      pick = int'($urandom_range(0, 9));
      op   = (pick < 8) ? 4'($urandom_range(0, 10)) : 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       d = 32'($urandom_range(0, 3));
        1:       d = 32'($urandom_range(0, 1000));
        default: d = $urandom;
      endcase
      if (pick < 4) run_token(1'b0, 4'd0, d, r);
      else if (op == 4'd10 && $urandom_range(0, 2) != 0) run_token(1'b0, 4'd0, d, r);
      else run_token(1'b1, op, d, r);
    end

    check("no_push_pop_overlap", 32'(overlap), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
